stereo_render_scheduler: RTL
============================

// Module: stereo_render_scheduler
// PURPOSE
//  Time-multiplexes one renderer instance between the left and right eye of a stereo frame.
//  On each new_frame pulse from video_sig_gen it latches a fresh camera pose, renders left then right eye
//  (right origin offset by EYE_SEP on x), and swaps the display/write frame-buffer halves only when both eyes completed.
//  Sits between the pose source (gyro/view pipeline) and the renderer; the TMDS/HDMI path reads display_buf_out.
// PARAMETERS
//  EYE_SEP        32'sd32768  right-eye x offset, signed Q16.16 (0.5 units)
//  TIMEOUT_CYCLES 200000      max cycles waiting for render_done_in per eye before forced advance
//  DROP_W         16          width of dropped-frame counter
// PORTS
//  clk_in             in   1       system clock; all I/O synchronous to it
//  rst_n_in           in   1       asynchronous active-low reset
//  enable_in          in   1       1 = schedule frames; 0 = finish current frame then idle
//  new_frame_in       in   1       1-cycle pulse, start of video frame
//  pose_valid_in      in   1       1-cycle strobe: pose_*_in valid
//  pose_x_in/_y_in/_z_in in 32 each camera origin, signed Q16.16
//  render_done_in     in   1       1-cycle pulse from renderer: current eye finished
//  start_out          out  1       1-cycle pulse: renderer begins eye in eye_out with ori_*_out
//  eye_out            out  1       0 = left, 1 = right
//  ori_x_out/_y_out/_z_out out 32 each origin applied to renderer, held stable while rendering
//  display_buf_out    out  1       buffer half scanned to HDMI
//  write_buf_out      out  1       buffer half renderer writes; always ~display_buf_out
//  busy_out           out  1       1 in any state other than READY
//  drops_out          out  DROP_W  frames where new_frame_in arrived while busy, saturating
//  timeout_out        out  1       sticky: some eye hit TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async, rst_n_in=0): state READY; start_out=0, eye_out=0, ori_*_out=0, display_buf_out=0,
//   write_buf_out=1, busy_out=0, drops_out=0, timeout_out=0, shadow pose=0, have_frame=0.
//   Reset mid-render abandons the frame; no start/done memory survives.
//  Shadow pose: pose_valid_in=1 loads pose_*_in into shadow regs every cycle, any state.
//  States: READY -> START_L -> WAIT_L -> START_R -> WAIT_R -> READY.
//  READY: on new_frame_in & enable_in: if have_frame, toggle display_buf_out; load ori_*_out from shadow
//   (bypass: if pose_valid_in same cycle, use pose_*_in); eye_out<=0; go START_L.
//  START_L/START_R: start_out=1 exactly this cycle; clear timeout counter; go WAIT_L/WAIT_R.
//   start_out thus rises 1 cycle after sampled new_frame_in (left) / render_done_in (left->right).
//  WAIT_L: on render_done_in: ori_x_out <= ori_x_out + EYE_SEP (32-bit wrap, no saturation), eye_out<=1, go START_R.
//  WAIT_R: on render_done_in: have_frame<=1, go READY; if new_frame_in same cycle & enable_in,
//   treat as READY-with-new_frame (swap, latch, go START_L); not counted as drop.
//  ori_y_out/ori_z_out unchanged between eyes; pose updates during a frame affect next frame only.
//  new_frame_in while busy (START_*/WAIT_*): drops_out++ saturating at all-ones; no swap, no restart.
//  enable_in=0: in-flight frame completes normally; READY ignores new_frame_in, drops not counted.
//  Timeout: counter increments each WAIT_* cycle; reaching TIMEOUT_CYCLES sets timeout_out (sticky until reset)
//   and advances exactly as if render_done_in arrived. render_done_in outside WAIT_* ignored.
//  busy_out = (state != READY), registered with state.
// TESTING
//  1 Reset, pose=(−20,0,140)<<16 strobed, new_frame -> start_out@+1, eye 0, ori_x=0xFFEC0000; done -> start,
//    eye 1, ori_x=0xFFEC8000; done -> READY, display_buf stays 0 (first frame).
//  2 Second new_frame after full frame -> display_buf 0->1, write_buf 1->0 same cycle as latch.
//  3 new_frame during WAIT_L three times -> drops_out=3, display_buf unchanged, eye sequence unaffected.
//  4 Hold render_done_in low with TIMEOUT_CYCLES=16 -> advance after 16 WAIT cycles each eye, timeout_out=1 sticky.
//  5 render_done_in and new_frame_in same cycle in WAIT_R -> swap + START_L next cycle, drops_out unchanged;
//    pose_valid_in same cycle -> ori_*_out takes new pose.
//  6 Drive rst_n_in low mid-WAIT_R -> all outputs at reset values immediately, no start_out after release until new_frame.

Source files
------------

// File: rtl/stereo_render_scheduler.sv
// Shares one renderer between left and right eye per video frame: latches a pose,
// renders left then right (x offset by EYE_SEP), and swaps buffer halves once both eyes finish.
module stereo_render_scheduler #(
  parameter logic signed [31:0] EYE_SEP        = 32'sd32768,
  parameter int unsigned        TIMEOUT_CYCLES = 200000,
  parameter int unsigned        DROP_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              enable_in,
  input  logic              new_frame_in,
  input  logic              pose_valid_in,
  input  logic [31:0]       pose_x_in,
  input  logic [31:0]       pose_y_in,
  input  logic [31:0]       pose_z_in,
  input  logic              render_done_in,
  output logic              start_out,
  output logic              eye_out,
  output logic [31:0]       ori_x_out,
  output logic [31:0]       ori_y_out,
  output logic [31:0]       ori_z_out,
  output logic              display_buf_out,
  output logic              write_buf_out,
  output logic              busy_out,
  output logic [DROP_W-1:0] drops_out,
  output logic              timeout_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {READY, START_L, WAIT_L, START_R, WAIT_R} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [31:0]         sh_x_q, sh_y_q, sh_z_q, sh_x_d, sh_y_d, sh_z_d;
  logic [31:0]         ori_x_q, ori_y_q, ori_z_q, ori_x_d, ori_y_d, ori_z_d;
  logic                eye_q, eye_d, disp_q, disp_d, wbuf_q, wbuf_d;
  logic                have_q, have_d, start_q, start_d, busy_q, busy_d;
  logic                tout_q, tout_d;
  logic [DROP_W-1:0]   drops_q, drops_d;
  logic                expire, advance, launch, swap, drop;

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    ori_x_d = ori_x_q;
    ori_y_d = ori_y_q;
    ori_z_d = ori_z_q;
    eye_d   = eye_q;
    disp_d  = disp_q;
    have_d  = have_q;
    tout_d  = tout_q;
    drops_d = drops_q;
    launch  = 1'b0;
    swap    = 1'b0;
    drop    = 1'b0;
    sh_x_d  = pose_valid_in ? pose_x_in : sh_x_q;
    sh_y_d  = pose_valid_in ? pose_y_in : sh_y_q;
    sh_z_d  = pose_valid_in ? pose_z_in : sh_z_q;
    expire  = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    advance = render_done_in | expire;

    case (state_q)
      READY: begin
        if (new_frame_in && enable_in) begin
          launch = 1'b1;
          swap   = have_q;
        end
      end
      START_L: begin
        tcnt_d  = '0;
        state_d = WAIT_L;
        drop    = new_frame_in;
      end
      WAIT_L: begin
        tcnt_d = tcnt_q + TW'(1);
        drop   = new_frame_in;
        if (advance) begin
          tout_d  = tout_q | expire;
          ori_x_d = ori_x_q + EYE_SEP;
          eye_d   = 1'b1;
          state_d = START_R;
        end
      end
      START_R: begin
        tcnt_d  = '0;
        state_d = WAIT_R;
        drop    = new_frame_in;
      end
      WAIT_R: begin
        tcnt_d = tcnt_q + TW'(1);
        if (advance) begin
          tout_d  = tout_q | expire;
          have_d  = 1'b1;
          state_d = READY;
          // Back-to-back frame: the one just finished is complete, so swap now
          if (new_frame_in && enable_in) begin
            launch = 1'b1;
            swap   = 1'b1;
          end
        end else begin
          drop = new_frame_in;
        end
      end
      default: state_d = READY;
    endcase

    if (launch) begin
      state_d = START_L;
      eye_d   = 1'b0;
      ori_x_d = pose_valid_in ? pose_x_in : sh_x_q;
      ori_y_d = pose_valid_in ? pose_y_in : sh_y_q;
      ori_z_d = pose_valid_in ? pose_z_in : sh_z_q;
    end
    if (swap) disp_d = ~disp_q;
    if (drop && (drops_q != '1)) drops_d = drops_q + DROP_W'(1);

    wbuf_d  = ~disp_d;
    start_d = (state_d == START_L) || (state_d == START_R);
    busy_d  = (state_d != READY);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= READY;
      tcnt_q  <= '0;
      sh_x_q  <= '0;
      sh_y_q  <= '0;
      sh_z_q  <= '0;
      ori_x_q <= '0;
      ori_y_q <= '0;
      ori_z_q <= '0;
      eye_q   <= 1'b0;
      disp_q  <= 1'b0;
      wbuf_q  <= 1'b1;
      have_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      sh_x_q  <= sh_x_d;
      sh_y_q  <= sh_y_d;
      sh_z_q  <= sh_z_d;
      ori_x_q <= ori_x_d;
      ori_y_q <= ori_y_d;
      ori_z_q <= ori_z_d;
      eye_q   <= eye_d;
      disp_q  <= disp_d;
      wbuf_q  <= wbuf_d;
      have_q  <= have_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
      drops_q <= drops_d;
    end
  end

  assign start_out       = start_q;
  assign eye_out         = eye_q;
  assign ori_x_out       = ori_x_q;
  assign ori_y_out       = ori_y_q;
  assign ori_z_out       = ori_z_q;
  assign display_buf_out = disp_q;
  assign write_buf_out   = wbuf_q;
  assign busy_out        = busy_q;
  assign drops_out       = drops_q;
  assign timeout_out     = tout_q;

endmodule
